// File: rtl/np_ftq_stage_if.sv
// rtl/np_ftq_stage_if.sv - FTQ head dequeue bus between the next-PC stage and fetch
interface np_ftq_stage_if #(
   parameter int PC_WIDTH    = 32,
   parameter int FETCH_WIDTH = 4,
   parameter int SID_WIDTH   = 16
);
   logic                   deq_valid;
   logic                   deq_ready;
   logic [PC_WIDTH-1:0]    deq_pc;
   logic [FETCH_WIDTH-1:0] deq_mask;
   logic [SID_WIDTH-1:0]   deq_sid;

   modport master (output deq_valid, deq_pc, deq_mask, deq_sid, input deq_ready);
   modport slave  (input deq_valid, deq_pc, deq_mask, deq_sid, output deq_ready);
endinterface

// File: rtl/np_ftq_stage.sv
// rtl/np_ftq_stage.sv - next-PC generator with one-entry predictor staging and fetch-target queue
module np_ftq_stage #(
   parameter int                FETCH_WIDTH     = 4,
   parameter int                INSN_BYTE_WIDTH = 4,
   parameter int                LINE_BYTE_WIDTH = 64,
   parameter int                PC_WIDTH        = 32,
   parameter int                NUM_PRED_SRC    = 3,
   parameter int                FTQ_DEPTH       = 8,
   parameter int                SID_WIDTH       = 16,
   parameter int                STOP_ON_MISPRED = 0,
   parameter int                WAIT_DELAY      = 2,
   parameter logic [PC_WIDTH-1:0] RESET_PC      = 32'h1000
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      recov_commit_valid_i,
   input  logic [PC_WIDTH-1:0]                       recov_commit_pc_i,
   input  logic                                      recov_rename_valid_i,
   input  logic [PC_WIDTH-1:0]                       recov_rename_pc_i,
   input  logic                                      int_valid_i,
   input  logic [PC_WIDTH-1:0]                       int_pc_i,
   input  logic                                      br_mispred_i,
   output logic                                      pred_req_valid_o,
   output logic [PC_WIDTH-1:0]                       pred_req_pc_o,
   input  logic [NUM_PRED_SRC*FETCH_WIDTH-1:0]       pred_taken_i,
   input  logic [NUM_PRED_SRC*FETCH_WIDTH*PC_WIDTH-1:0] pred_target_i,
   np_ftq_stage_if.master                            deq_bus,
   output logic [$clog2(FTQ_DEPTH):0]                ftq_count_o
);
   localparam int LINE_LOG = $clog2(LINE_BYTE_WIDTH);
   localparam int PTR_W    = $clog2(FTQ_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int LANE_W   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int DLY_W    = (WAIT_DELAY > 1) ? WAIT_DELAY - 1 : 1;

   typedef enum logic {PH_FETCH, PH_WAIT} phase_e;

   phase_e                 phase_q, phase_d;
   logic [DLY_W-1:0]       dly_q, dly_d;
   logic [PC_WIDTH-1:0]    pc_seq_q, pc_seq_d;
   logic                   stage_valid_q, stage_valid_d;
   logic [PC_WIDTH-1:0]    stage_pc_q, stage_pc_d;
   logic [FETCH_WIDTH-1:0] stage_mask_q, stage_mask_d;
   logic                   dec_valid_q, dec_valid_d;
   logic                   dec_taken_q, dec_taken_d;
   logic [LANE_W-1:0]      dec_lane_q, dec_lane_d;
   logic [PC_WIDTH-1:0]    dec_target_q, dec_target_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [SID_WIDTH-1:0]   sid_q, sid_d;

   logic [PC_WIDTH-1:0]    ftq_pc_q   [FTQ_DEPTH];
   logic [FETCH_WIDTH-1:0] ftq_mask_q [FTQ_DEPTH];
   logic [SID_WIDTH-1:0]   ftq_sid_q  [FTQ_DEPTH];

   logic                   live_taken, sel_taken;
   logic [LANE_W-1:0]      live_lane, sel_lane;
   logic [PC_WIDTH-1:0]    live_target, sel_target;
   logic                   redirect, deq_fire, ftq_full, stage_push, enq, pred_redir, gen_en;
   logic                   mispred_tap;
   logic [PC_WIDTH-1:0]    base;
   logic [FETCH_WIDTH-1:0] gen_mask, enq_mask;
   int unsigned            line_off;

   // Descending loops: the final write is the lowest taken lane, lowest source within it.
   always_comb begin
      live_taken  = 1'b0;
      live_lane   = '0;
      live_target = '0;
      for (int l = FETCH_WIDTH - 1; l >= 0; l--) begin
         for (int s = NUM_PRED_SRC - 1; s >= 0; s--) begin
            if (stage_mask_q[l] && pred_taken_i[s*FETCH_WIDTH + l]) begin
               live_taken  = 1'b1;
               live_lane   = LANE_W'(l);
               live_target = pred_target_i[(s*FETCH_WIDTH + l)*PC_WIDTH +: PC_WIDTH];
            end
         end
      end
   end

   assign sel_taken  = dec_valid_q ? dec_taken_q  : live_taken;
   assign sel_lane   = dec_valid_q ? dec_lane_q   : live_lane;
   assign sel_target = dec_valid_q ? dec_target_q : live_target;

   assign redirect   = recov_commit_valid_i | recov_rename_valid_i | int_valid_i;
   assign deq_fire   = (count_q != '0) && deq_bus.deq_ready;
   assign ftq_full   = (count_q == CNT_W'(FTQ_DEPTH));
   assign stage_push = stage_valid_q && (!ftq_full || deq_fire);
   assign enq        = stage_push && !redirect;
   assign pred_redir = stage_valid_q && sel_taken;
   assign gen_en     = (phase_q == PH_FETCH) && (!stage_valid_q || stage_push || redirect);

   always_comb begin
      if (recov_commit_valid_i)      base = recov_commit_pc_i;
      else if (recov_rename_valid_i) base = recov_rename_pc_i;
      else if (int_valid_i)          base = int_pc_i;
      else if (pred_redir)           base = sel_target;
      else                           base = pc_seq_q;
   end

   always_comb begin
      line_off = 32'(base[LINE_LOG-1:0]);
      gen_mask = '0;
      enq_mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         gen_mask[i] = (line_off + 32'(i*INSN_BYTE_WIDTH)) < 32'(LINE_BYTE_WIDTH);
         enq_mask[i] = stage_mask_q[i] && (!sel_taken || (LANE_W'(i) <= sel_lane));
      end
   end

   always_comb begin
      pc_seq_d      = pc_seq_q;
      stage_valid_d = stage_valid_q;
      stage_pc_d    = stage_pc_q;
      stage_mask_d  = stage_mask_q;
      dec_valid_d   = dec_valid_q;
      dec_taken_d   = dec_taken_q;
      dec_lane_d    = dec_lane_q;
      dec_target_d  = dec_target_q;

      if (redirect || stage_push) begin
         stage_valid_d = 1'b0;
         dec_valid_d   = 1'b0;
      end else if (stage_valid_q && !dec_valid_q) begin
         dec_valid_d  = 1'b1;
         dec_taken_d  = live_taken;
         dec_lane_d   = live_lane;
         dec_target_d = live_target;
      end

      if (gen_en) begin
         stage_valid_d = 1'b1;
         stage_pc_d    = base;
         stage_mask_d  = gen_mask;
         pc_seq_d      = base + PC_WIDTH'($countones(gen_mask) * INSN_BYTE_WIDTH);
      end else if (redirect || (stage_push && pred_redir)) begin
         // Not generating (WAIT): remember where to resume once fetch restarts.
         pc_seq_d = base;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      sid_d    = sid_q;
      if (enq) sid_d = sid_q + SID_WIDTH'($countones(enq_mask));
      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq)      wr_ptr_d = wr_ptr_q + 1'b1;
         if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq_fire);
      end
   end

   assign mispred_tap = (WAIT_DELAY == 1) ? br_mispred_i : dly_q[DLY_W-1];

   always_comb begin
      phase_d = phase_q;
      dly_d   = recov_commit_valid_i ? '0 : ((dly_q << 1) | DLY_W'(br_mispred_i));
      if (STOP_ON_MISPRED != 0) begin
         case (phase_q)
            PH_FETCH: if (mispred_tap && !recov_commit_valid_i) phase_d = PH_WAIT;
            PH_WAIT:  if (recov_commit_valid_i)                 phase_d = PH_FETCH;
            default:  phase_d = PH_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q       <= PH_FETCH;
         dly_q         <= '0;
         pc_seq_q      <= RESET_PC;
         stage_valid_q <= 1'b0;
         stage_pc_q    <= '0;
         stage_mask_q  <= '0;
         dec_valid_q   <= 1'b0;
         dec_taken_q   <= 1'b0;
         dec_lane_q    <= '0;
         dec_target_q  <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         sid_q         <= SID_WIDTH'(1);
      end else begin
         phase_q       <= phase_d;
         dly_q         <= dly_d;
         pc_seq_q      <= pc_seq_d;
         stage_valid_q <= stage_valid_d;
         stage_pc_q    <= stage_pc_d;
         stage_mask_q  <= stage_mask_d;
         dec_valid_q   <= dec_valid_d;
         dec_taken_q   <= dec_taken_d;
         dec_lane_q    <= dec_lane_d;
         dec_target_q  <= dec_target_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         sid_q         <= sid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         ftq_pc_q[wr_ptr_q]   <= stage_pc_q;
         ftq_mask_q[wr_ptr_q] <= enq_mask;
         ftq_sid_q[wr_ptr_q]  <= sid_q;
      end
   end

   assign pred_req_valid_o  = gen_en;
   assign pred_req_pc_o     = base;
   assign deq_bus.deq_valid = (count_q != '0);
   assign deq_bus.deq_pc    = (count_q != '0) ? ftq_pc_q[rd_ptr_q]   : '0;
   assign deq_bus.deq_mask  = (count_q != '0) ? ftq_mask_q[rd_ptr_q] : '0;
   assign deq_bus.deq_sid   = (count_q != '0) ? ftq_sid_q[rd_ptr_q]  : '0;
   assign ftq_count_o       = count_q;
endmodule

// File: tb/tb_np_ftq_stage.sv
// tb/tb_np_ftq_stage.sv - scoreboard bench for np_ftq_stage
module tb_np_ftq_stage;
   localparam int FW  = 4;
   localparam int PCW = 32;
   localparam int NS  = 3;
   localparam int SW  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic recov_commit_valid = 1'b0, recov_rename_valid = 1'b0, int_valid = 1'b0, br_mispred = 1'b0;
   logic [PCW-1:0] recov_commit_pc = '0, recov_rename_pc = '0, int_pc = '0;
   logic [NS*FW-1:0]     pred_taken;
   logic [NS*FW*PCW-1:0] pred_target;
   logic           req_valid_a, req_valid_w;
   logic [PCW-1:0] req_pc_a, req_pc_w;
   logic [3:0]     count_a, count_w;

   int total = 0;
   int bad   = 0;
   int pred_mode = 0;
   logic [PCW-1:0] tb_stage_pc;
   int hold_cnt;
   bit mon_en = 1'b0;
   logic [SW-1:0] prev_sid;
   logic [FW-1:0] prev_mask;

   typedef struct {
      logic [PCW-1:0] pc;
      logic [FW-1:0]  mask;
      logic [SW-1:0]  sid;
      int             mode;   // 0 absolute sid, 1 sid follows previous dequeue, 2 sid not checked
   } exp_t;
   exp_t exp_q[$];

   np_ftq_stage_if #(.PC_WIDTH(PCW), .FETCH_WIDTH(FW), .SID_WIDTH(SW)) ifa ();
   np_ftq_stage_if #(.PC_WIDTH(PCW), .FETCH_WIDTH(FW), .SID_WIDTH(SW)) ifw ();

   np_ftq_stage #(.STOP_ON_MISPRED(0)) dut_a (
      .clk(clk), .rst(rst),
      .recov_commit_valid_i(recov_commit_valid), .recov_commit_pc_i(recov_commit_pc),
      .recov_rename_valid_i(recov_rename_valid), .recov_rename_pc_i(recov_rename_pc),
      .int_valid_i(int_valid), .int_pc_i(int_pc), .br_mispred_i(br_mispred),
      .pred_req_valid_o(req_valid_a), .pred_req_pc_o(req_pc_a),
      .pred_taken_i(pred_taken), .pred_target_i(pred_target),
      .deq_bus(ifa), .ftq_count_o(count_a)
   );

   np_ftq_stage #(.STOP_ON_MISPRED(1), .WAIT_DELAY(2)) dut_w (
      .clk(clk), .rst(rst),
      .recov_commit_valid_i(recov_commit_valid), .recov_commit_pc_i(recov_commit_pc),
      .recov_rename_valid_i(recov_rename_valid), .recov_rename_pc_i(recov_rename_pc),
      .int_valid_i(int_valid), .int_pc_i(int_pc), .br_mispred_i(br_mispred),
      .pred_req_valid_o(req_valid_w), .pred_req_pc_o(req_pc_w),
      .pred_taken_i(pred_taken), .pred_target_i(pred_target),
      .deq_bus(ifw), .ftq_count_o(count_w)
   );

   always #5 clk = ~clk;

   // Predictor model: answers for the block dut_a requested most recently.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_stage_pc <= '0;
         hold_cnt    <= 0;
      end else if (req_valid_a) begin
         tb_stage_pc <= req_pc_a;
         hold_cnt    <= 0;
      end else begin
         hold_cnt <= hold_cnt + 1;
      end
   end

   always_comb begin
      pred_taken  = '0;
      pred_target = '0;
      if (pred_mode == 1 && tb_stage_pc == 32'h1000) begin
         pred_taken[1*FW+1] = 1'b1; pred_target[(1*FW+1)*PCW +: PCW] = 32'h3000;
         pred_taken[2*FW+1] = 1'b1; pred_target[(2*FW+1)*PCW +: PCW] = 32'h4000;
         pred_taken[0*FW+3] = 1'b1; pred_target[(0*FW+3)*PCW +: PCW] = 32'h5000;
      end else if (pred_mode == 2 && tb_stage_pc == 32'h1080) begin
         if (hold_cnt == 0) begin
            pred_taken[1*FW+2] = 1'b1; pred_target[(1*FW+2)*PCW +: PCW] = 32'h6000;
         end else begin
            pred_taken[0*FW+0] = 1'b1; pred_target[(0*FW+0)*PCW +: PCW] = 32'h7000;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [PCW-1:0] pc, input logic [FW-1:0] mask,
                           input logic [SW-1:0] sid, input int mode);
      exp_t e;
      e.pc = pc; e.mask = mask; e.sid = sid; e.mode = mode;
      exp_q.push_back(e);
   endtask

   task automatic mon_step();
      exp_t e;
      if (mon_en && ifa.deq_valid && ifa.deq_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_eq("deq_pc", ifa.deq_pc, e.pc);
         check_eq("deq_mask", ifa.deq_mask, e.mask);
         if (e.mode == 0)
            check_eq("deq_sid", ifa.deq_sid, e.sid);
         else if (e.mode == 1)
            check_eq("deq_sid_rel", ifa.deq_sid, prev_sid + SW'($countones(prev_mask)));
         prev_sid  = ifa.deq_sid;
         prev_mask = ifa.deq_mask;
      end
   endtask

   always @(negedge clk) mon_step();

   task automatic do_reset(input int mode, input logic ready);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("rst_deq_valid", ifa.deq_valid, 0);
      check_eq("rst_count", count_a, 0);
      check_eq("rst_deq_pc", ifa.deq_pc, 0);
      check_eq("rst_deq_mask", ifa.deq_mask, 0);
      check_eq("rst_deq_sid", ifa.deq_sid, 0);
      mon_en = 1'b0;
      exp_q.delete();
      pred_mode = mode;
      recov_commit_valid = 1'b0; recov_rename_valid = 1'b0; int_valid = 1'b0; br_mispred = 1'b0;
      ifa.deq_ready = ready;
      ifw.deq_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("rst_req_valid", req_valid_a, 1);
      check_eq("rst_req_pc", req_pc_a, 32'h1000);
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check_eq(tag, exp_q.size(), 0);
      mon_en = 1'b0;
   endtask

   initial begin
      ifa.deq_ready = 1'b0;
      ifw.deq_ready = 1'b1;

      // Sequential fetch from reset
      do_reset(0, 1'b1);
      push_exp(32'h1000, 4'b1111, 1, 0);
      push_exp(32'h1010, 4'b1111, 5, 0);
      push_exp(32'h1020, 4'b1111, 9, 0);
      push_exp(32'h1030, 4'b1111, 13, 0);
      push_exp(32'h1040, 4'b1111, 17, 0);
      mon_en = 1'b1;
      drain("seq_drain", 40);

      // Commit redirect near line end
      do_reset(0, 1'b0);
      push_exp(32'h2038, 4'b0011, 0, 2);
      push_exp(32'h2040, 4'b1111, 0, 1);
      push_exp(32'h2050, 4'b1111, 0, 1);
      mon_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      recov_commit_valid = 1'b1; recov_commit_pc = 32'h2038;
      @(posedge clk); #1;
      recov_commit_valid = 1'b0;
      check_eq("commit_flush_count", count_a, 0);
      ifa.deq_ready = 1'b1;
      drain("commit_drain", 40);

      // Predicted-taken: lane priority then source priority
      do_reset(1, 1'b1);
      push_exp(32'h1000, 4'b0011, 1, 0);
      push_exp(32'h3000, 4'b1111, 3, 0);
      push_exp(32'h3010, 4'b1111, 7, 0);
      mon_en = 1'b1;
      drain("pred_drain", 40);

      // Back-pressure: saturate, held decision, FIFO order
      do_reset(2, 1'b0);
      for (int i = 0; i < 8; i++) push_exp(32'h1000 + 32'(16*i), 4'b1111, SW'(1 + 4*i), 0);
      push_exp(32'h1080, 4'b0111, 33, 0);
      push_exp(32'h6000, 4'b1111, 36, 0);
      push_exp(32'h6010, 4'b1111, 40, 0);
      mon_en = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_eq("full_count", count_a, 8);
      check_eq("held_no_req", req_valid_a, 0);
      ifa.deq_ready = 1'b1;
      drain("full_drain", 60);

      // Rename + interrupt together with 5 queued, same-cycle pop
      do_reset(0, 1'b0);
      push_exp(32'h1000, 4'b1111, 1, 0);
      push_exp(32'h8000, 4'b1111, 0, 2);
      push_exp(32'h8010, 4'b1111, 0, 1);
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (count_a == 5) break;
      end
      check_eq("fill5_count", count_a, 5);
      recov_rename_valid = 1'b1; recov_rename_pc = 32'h8000;
      int_valid = 1'b1; int_pc = 32'h9000;
      ifa.deq_ready = 1'b1;
      @(posedge clk); #1;
      recov_rename_valid = 1'b0; int_valid = 1'b0;
      check_eq("flush_count", count_a, 0);
      check_eq("flush_deq_valid", ifa.deq_valid, 0);
      drain("flush_drain", 40);

      // Stop-fetch-on-mispredict mode
      do_reset(0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      br_mispred = 1'b1;
      check_eq("wait_gen_t", req_valid_w, 1);
      @(posedge clk); #1;
      br_mispred = 1'b0;
      check_eq("wait_gen_t1", req_valid_w, 1);
      for (int k = 2; k < 6; k++) begin
         @(posedge clk); #1;
         check_eq($sformatf("wait_gen_off_t%0d", k), req_valid_w, 0);
         check_eq($sformatf("nowait_gen_t%0d", k), req_valid_a, 1);
      end
      @(posedge clk); #1;
      recov_commit_valid = 1'b1; recov_commit_pc = 32'hA000;
      check_eq("wait_gen_t6", req_valid_w, 0);
      @(posedge clk); #1;
      recov_commit_valid = 1'b0;
      check_eq("resume_req_valid", req_valid_w, 1);
      check_eq("resume_req_pc", req_pc_w, 32'hA000);
      repeat (2) @(posedge clk);
      #1;
      check_eq("resume_deq_valid", ifw.deq_valid, 1);
      check_eq("resume_deq_pc", ifw.deq_pc, 32'hA000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
